// File: rtl/fib_nth_ctrl.sv
// fib_nth_ctrl: request/response controller returning the single Fibonacci
// term F(idx) mod 2^W, plus a flag that is set iff the true term is >= 2^W.
// One request is in flight at a time. Valid/ready handshakes are used on both
// the request side and the response side.
//
// Optional feature: define FIB_NTH_CTRL_DOUBLE_RATE_EN to make RUN advance
// two terms per cycle while at least two steps remain. Results are identical
// in both builds; only the latency changes.
module fib_nth_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_num,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [W-1:0]     OneW   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] OneIdx = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  // (a, b) always holds the consecutive terms (F(n), F(n+1)); ovf_a/ovf_b
  // record whether the true value of each term has reached 2^W.
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             ovf_a_q, ovf_a_d;
  logic             ovf_b_q, ovf_b_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rsp_num_q, rsp_num_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             accept;
  logic             cnt_zero;
  logic [W:0]       sum_ab;

`ifdef FIB_NTH_CTRL_DOUBLE_RATE_EN
  // a + 2b can carry two bits past W.
  logic [W+1:0]     sum_a2b;
  logic             cnt_ge2;
`endif

  assign accept   = req_valid && req_ready;
  assign cnt_zero = (cnt_q == '0);
  assign sum_ab   = {1'b0, a_q} + {1'b0, b_q};

`ifdef FIB_NTH_CTRL_DOUBLE_RATE_EN
  assign sum_a2b  = {2'b00, a_q} + {1'b0, b_q, 1'b0};
  assign cnt_ge2  = (cnt_q >= IDX_W'(2));
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: no same-cycle turnaround from DONE to a new request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)    state_d = StRun;
      StRun:  if (cnt_zero)  state_d = StDone;
      StDone: if (rsp_ready) state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
    rsp_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    rsp_num   = rsp_num_q;
    rsp_ovf   = rsp_ovf_q;
  end

  // Datapath next-state: load on acceptance, step in RUN, capture on completion.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    ovf_a_d   = ovf_a_q;
    ovf_b_d   = ovf_b_q;
    cnt_d     = cnt_q;
    rsp_num_d = rsp_num_q;
    rsp_ovf_d = rsp_ovf_q;

    if (state_q == StIdle) begin
      if (accept) begin
        a_d     = '0;
        b_d     = OneW;
        ovf_a_d = 1'b0;
        ovf_b_d = 1'b0;
        cnt_d   = req_idx;
      end
    end else if (state_q == StRun) begin
      if (cnt_zero) begin
        rsp_num_d = a_q;
        rsp_ovf_d = ovf_a_q;
`ifdef FIB_NTH_CTRL_DOUBLE_RATE_EN
      end else if (cnt_ge2) begin
        // (F(n), F(n+1)) -> (F(n+2), F(n+3)); both new terms depend on both
        // old ones, so either incoming flag taints both.
        a_d     = sum_ab[W-1:0];
        b_d     = sum_a2b[W-1:0];
        ovf_a_d = ovf_a_q | ovf_b_q | sum_ab[W];
        ovf_b_d = ovf_a_q | ovf_b_q | (sum_a2b[W+1:W] != 2'b00);
        cnt_d   = cnt_q - IDX_W'(2);
`endif
      end else begin
        a_d     = b_q;
        b_d     = sum_ab[W-1:0];
        ovf_a_d = ovf_b_q;
        ovf_b_d = ovf_a_q | ovf_b_q | sum_ab[W];
        cnt_d   = cnt_q - OneIdx;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= OneW;
      ovf_a_q   <= 1'b0;
      ovf_b_q   <= 1'b0;
      cnt_q     <= '0;
      rsp_num_q <= '0;
      rsp_ovf_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      ovf_a_q   <= ovf_a_d;
      ovf_b_q   <= ovf_b_d;
      cnt_q     <= cnt_d;
      rsp_num_q <= rsp_num_d;
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  // A stalled response must hold its payload until the client takes it.
  rsp_hold_a: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_num) && $stable(rsp_ovf)));

  // Accepting a request and being busy are mutually exclusive.
  ready_busy_a: assert property (@(posedge clk) disable iff (rst)
    !(req_ready && busy));

endmodule

// File: tb/tb_fib_nth_ctrl.sv
// Self-checking bench for fib_nth_ctrl: directed corner cases plus random
// back-to-back requests checked against an arithmetic Fibonacci model.
// FIB_NTH_CTRL_DOUBLE_RATE_EN selects the expected latency rule.
module tb_fib_nth_ctrl;

  localparam int W     = 16;
  localparam int IDX_W = 8;
  localparam int MaxWait = 600;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [IDX_W-1:0] req_idx = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_num;
  logic             rsp_ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  fib_nth_ctrl #(
    .W     (W),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_num   (rsp_num),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // F(idx) mod 2^W, and whether the exact F(idx) reaches 2^W. The exact
  // sequence is saturated at 2^W so it never outgrows a longint.
  function automatic void ref_fib(input int idx, output logic [W-1:0] num, output logic ovf);
    longint cap = longint'(1) << W;
    longint m0 = 0, m1 = 1, e0 = 0, e1 = 1, t;
    for (int k = 0; k < idx; k++) begin
      t  = (m0 + m1) % cap;
      m0 = m1;
      m1 = t;
      t  = e0 + e1;
      if (t > cap) t = cap;
      e0 = e1;
      e1 = t;
    end
    num = W'(m0);
    ovf = (e0 >= cap);
  endfunction

  function automatic int ref_latency(input int idx);
`ifdef FIB_NTH_CTRL_DOUBLE_RATE_EN
    return (idx + 1) / 2 + 1;
`else
    return idx + 1;
`endif
  endfunction

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, optionally poke req_valid during RUN, stall
  // the response for 'hold' cycles, then complete and confirm return to IDLE.
  task automatic do_req(input int idx, input int hold, input bit spurious);
    logic [W-1:0] exp_num;
    logic         exp_ovf;
    int           lat;
    ref_fib(idx, exp_num, exp_ovf);

    check_eq("req_ready_idle", 32'(req_ready), 32'(1));
    req_valid = 1'b1;
    req_idx   = IDX_W'(idx);
    rsp_ready = (hold == 0);
    wait_clk();
    req_valid = 1'b0;

    lat = 0;
    do begin
      check_eq("busy_run", 32'(busy), 32'(1));
      check_eq("req_ready_run", 32'(req_ready), 32'(0));
      if (spurious && lat == 0) begin
        req_valid = 1'b1;
        req_idx   = IDX_W'(idx + 3);
      end else begin
        req_valid = 1'b0;
      end
      wait_clk();
      lat++;
    end while (!rsp_valid && lat < MaxWait);
    req_valid = 1'b0;

    check_eq("rsp_valid", 32'(rsp_valid), 32'(1));
    check_eq("latency", 32'(lat), 32'(ref_latency(idx)));
    check_eq("rsp_num", 32'(rsp_num), 32'(exp_num));
    check_eq("rsp_ovf", 32'(rsp_ovf), 32'(exp_ovf));

    for (int h = 0; h < hold; h++) begin
      wait_clk();
      check_eq("hold_valid", 32'(rsp_valid), 32'(1));
      check_eq("hold_num", 32'(rsp_num), 32'(exp_num));
      check_eq("hold_ovf", 32'(rsp_ovf), 32'(exp_ovf));
      check_eq("hold_busy", 32'(busy), 32'(1));
      check_eq("hold_req_ready", 32'(req_ready), 32'(0));
    end

    rsp_ready = 1'b1;
    wait_clk();
    check_eq("post_valid", 32'(rsp_valid), 32'(0));
    check_eq("post_busy", 32'(busy), 32'(0));
    check_eq("post_req_ready", 32'(req_ready), 32'(1));
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) wait_clk();
    check_eq("rst_req_ready", 32'(req_ready), 32'(0));
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_rsp_num", 32'(rsp_num), 32'(0));
    check_eq("rst_rsp_ovf", 32'(rsp_ovf), 32'(0));
    rst = 1'b0;
    wait_clk();
    check_eq("rel_req_ready", 32'(req_ready), 32'(1));
    check_eq("rel_busy", 32'(busy), 32'(0));
    check_eq("rel_rsp_num", 32'(rsp_num), 32'(0));

    // Directed cases: zero index, spurious request in RUN, overflow edge,
    // wrapped value, response backpressure, maximum index.
    do_req(0, 0, 1'b0);
    do_req(10, 0, 1'b1);
    do_req(24, 0, 1'b0);
    do_req(25, 0, 1'b0);
    do_req(30, 0, 1'b0);
    do_req(7, 5, 1'b0);
    do_req(255, 1, 1'b0);
    do_req(1, 0, 1'b0);
    do_req(2, 2, 1'b1);

    // Reset three cycles into RUN discards the pending result.
    req_valid = 1'b1;
    req_idx   = IDX_W'(20);
    wait_clk();
    req_valid = 1'b0;
    repeat (3) wait_clk();
    check_eq("midrst_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check_eq("midrst_req_ready_in_rst", 32'(req_ready), 32'(0));
    wait_clk();
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("midrst_busy", 32'(busy), 32'(0));
    check_eq("midrst_req_ready", 32'(req_ready), 32'(0));
    check_eq("midrst_rsp_num", 32'(rsp_num), 32'(0));
    rst = 1'b0;
    wait_clk();
    check_eq("midrst_req_ready_rel", 32'(req_ready), 32'(1));
    do_req(5, 0, 1'b0);

    // Random back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      do_req(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
